// File: rtl/udp_rx_mch_parser.sv
// Multi-channel UDP receive parser: decodes Ethernet/IPv4/UDP headers from a 64-bit beat stream
// and routes each payload by destination port into per-channel FWFT FIFOs, with admission control.
module udp_rx_mch_parser #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_tvalid,
    input  logic [63:0]             rx_tdata,
    input  logic [7:0]              rx_tkeep,
    input  logic                    rx_tlast,
    input  logic [47:0]             fpga_mac_adr,
    input  logic [47:0]             host_mac_adr,
    input  logic [31:0]             fpga_ip_adr,
    input  logic [31:0]             host_ip_adr,
    input  logic [16*NUM_CH-1:0]    ch_port,
    input  logic [NUM_CH-1:0]       ch_enable,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [64*NUM_CH-1:0]    out_data,
    output logic [8*NUM_CH-1:0]     out_keep,
    output logic [NUM_CH-1:0]       out_last,
    output logic                    arp_trigger,
    output logic [CNT_W*NUM_CH-1:0] pkt_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic [CNT_W-1:0]        seq_err_cnt,
    output logic [3:0]              sm_state
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_HDR1, S_HDR2, S_HDR3, S_HDR4, S_SEQ, S_PAYLOAD, S_ARP_WAIT, S_DROP
    } state_t;

    state_t state_q, state_d, cur;
    logic             in_valid_q, in_last_q, in_sop_q, first_q;
    logic [63:0]      in_data_q;
    logic [7:0]       in_keep_q;
    logic [CH_W-1:0]  ch_q, ch_d, hit_ch;
    logic             hit, fail, pkt_inc, seq_upd, seq_err_inc, arp_d, arp_q;
    logic [1:0]       drop_inc;
    logic             wr_en_q, wr_en_d, wr_last_q, wr_last_d;
    logic [CH_W-1:0]  wr_ch_q;
    logic [63:0]      wr_data_q, wr_data_d;
    logic [7:0]       wr_keep_q, wr_keep_d;
    logic [AW:0]      fifo_cnt [NUM_CH];
    logic [AW:0]      free_ent;
    logic [15:0]      pay_bytes;
    logic [16:0]      beats_need;
    logic [CNT_W-1:0] pkt_cnt_q [NUM_CH];
    logic [CNT_W-1:0] drop_cnt_q, seq_err_cnt_q;
    logic [47:0]      exp_seq_q [NUM_CH];
    logic [NUM_CH-1:0] seeded_q;

    // SOP is tagged at the input register so the FSM sees it alongside the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
            in_last_q  <= 1'b0;
            in_sop_q   <= 1'b0;
            first_q    <= 1'b1;
            in_data_q  <= '0;
            in_keep_q  <= '0;
        end else begin
            in_valid_q <= rx_tvalid;
            if (rx_tvalid) begin
                in_data_q <= rx_tdata;
                in_keep_q <= rx_tkeep;
                in_last_q <= rx_tlast;
                in_sop_q  <= first_q;
                first_q   <= rx_tlast;
            end
        end
    end

    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i] && (ch_port[16*i +: 16] == in_data_q[31:16])) begin
                hit    = 1'b1;
                hit_ch = CH_W'(i);
            end
        end
    end

    assign pay_bytes  = in_data_q[15:0] - 16'd14;
    assign beats_need = ({1'b0, pay_bytes} + 17'd7) >> 3;
    assign free_ent   = (AW+1)'(FIFO_DEPTH) - fifo_cnt[hit_ch];

    always_comb begin
        state_d     = state_q;
        cur         = state_q;
        ch_d        = ch_q;
        fail        = 1'b0;
        drop_inc    = 2'd0;
        pkt_inc     = 1'b0;
        seq_upd     = 1'b0;
        seq_err_inc = 1'b0;
        arp_d       = 1'b0;
        wr_en_d     = 1'b0;
        wr_data_d   = in_data_q;
        wr_keep_d   = 8'hFF;
        wr_last_d   = 1'b0;
        if (in_valid_q) begin
            // A new frame start abandons whatever packet was in flight.
            if (in_sop_q) begin
                if (state_q != S_IDLE) drop_inc = 2'd1;
                cur = S_IDLE;
            end
            case (cur)
                S_IDLE: begin
                    if (((in_data_q[63:16] == fpga_mac_adr) || (in_data_q[63:16] == '1)) &&
                        (in_data_q[15:0] == host_mac_adr[47:32]))
                        state_d = S_HDR1;
                    else
                        fail = 1'b1;
                end
                S_HDR1: begin
                    if (in_data_q[63:32] != host_mac_adr[31:0]) begin
                        fail = 1'b1;
                    end else if (in_data_q[31:16] == 16'h0806) begin
                        arp_d   = in_last_q;
                        state_d = in_last_q ? S_IDLE : S_ARP_WAIT;
                    end else if ((in_data_q[31:16] == 16'h0800) && (in_data_q[15:8] == 8'h45) && !in_last_q) begin
                        state_d = S_HDR2;
                    end else begin
                        fail = 1'b1;
                    end
                end
                S_HDR2: begin
                    if ((in_data_q[7:0] == 8'h11) && !in_last_q) state_d = S_HDR3;
                    else fail = 1'b1;
                end
                S_HDR3: begin
                    if ((in_data_q[47:16] == host_ip_adr) && (in_data_q[15:0] == fpga_ip_adr[31:16]) && !in_last_q)
                        state_d = S_HDR4;
                    else
                        fail = 1'b1;
                end
                S_HDR4: begin
                    if ((in_data_q[63:48] == fpga_ip_adr[15:0]) && hit && (in_data_q[15:0] >= 16'd14) &&
                        (17'(free_ent) >= beats_need) && !in_last_q) begin
                        ch_d    = hit_ch;
                        state_d = S_SEQ;
                    end else begin
                        fail = 1'b1;
                    end
                end
                S_SEQ: begin
                    seq_upd     = 1'b1;
                    seq_err_inc = seeded_q[ch_q] && (in_data_q[47:0] != exp_seq_q[ch_q]);
                    pkt_inc     = in_last_q;
                    state_d     = in_last_q ? S_IDLE : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    wr_en_d = 1'b1;
                    if (in_last_q) begin
                        wr_keep_d = in_keep_q;
                        wr_last_d = 1'b1;
                        pkt_inc   = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_ARP_WAIT: begin
                    arp_d = in_last_q;
                    if (in_last_q) state_d = S_IDLE;
                end
                S_DROP: if (in_last_q) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (fail) begin
                drop_inc = drop_inc + 2'd1;
                state_d  = in_last_q ? S_IDLE : S_DROP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            arp_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_ch_q       <= '0;
            wr_data_q     <= '0;
            wr_keep_q     <= '0;
            wr_last_q     <= 1'b0;
            drop_cnt_q    <= '0;
            seq_err_cnt_q <= '0;
            seeded_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pkt_cnt_q[i] <= '0;
                exp_seq_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            arp_q      <= arp_d;
            wr_en_q    <= wr_en_d;
            wr_ch_q    <= ch_q;
            wr_data_q  <= wr_data_d;
            wr_keep_q  <= wr_keep_d;
            wr_last_q  <= wr_last_d;
            drop_cnt_q <= drop_cnt_q + CNT_W'(drop_inc);
            if (seq_err_inc) seq_err_cnt_q <= seq_err_cnt_q + 1'b1;
            if (pkt_inc) pkt_cnt_q[ch_q] <= pkt_cnt_q[ch_q] + 1'b1;
            if (seq_upd) begin
                exp_seq_q[ch_q] <= in_data_q[47:0] + 48'd1;
                seeded_q[ch_q]  <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [72:0]   mem [FIFO_DEPTH];
            logic [AW-1:0] wr_ptr_q, rd_ptr_q;
            logic [AW:0]   cnt_q;
            logic          push, pop;
            logic [72:0]   head;

            assign push = wr_en_q && (wr_ch_q == CH_W'(gi));
            assign pop  = (cnt_q != '0) && out_ready[gi];
            assign head = mem[rd_ptr_q];

            always_ff @(posedge clk) begin
                if (push) mem[wr_ptr_q] <= {wr_data_q, wr_keep_q, wr_last_q};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                    if (push && !pop)      cnt_q <= cnt_q + 1'b1;
                    else if (!push && pop) cnt_q <= cnt_q - 1'b1;
                end
            end

            assign fifo_cnt[gi]               = cnt_q;
            assign out_valid[gi]              = (cnt_q != '0);
            assign out_data[64*gi +: 64]      = head[72:9];
            assign out_keep[8*gi +: 8]        = head[8:1];
            assign out_last[gi]               = head[0];
            assign pkt_cnt[CNT_W*gi +: CNT_W] = pkt_cnt_q[gi];
        end
    endgenerate

    assign arp_trigger = arp_q;
    assign drop_cnt    = drop_cnt_q;
    assign seq_err_cnt = seq_err_cnt_q;
    assign sm_state    = state_q;

endmodule
